// File: rtl/fft_bf_sched_if.sv
// Butterfly scheduler bus: data RAM read/write ports, twiddle ROM and butterfly datapath.
// master = scheduler side, slave = RAM/ROM/butterfly side.
interface fft_bf_sched_if #(
  parameter int LOG2N = 8
);
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_p;
  logic [LOG2N-1:0] rd_addr_q;
  logic [31:0]      rd_p;
  logic [31:0]      rd_q;
  logic [LOG2N-2:0] tw_addr;
  logic [31:0]      tw;
  logic             bf_en;
  logic [31:0]      bf_xp;
  logic [31:0]      bf_xq;
  logic [31:0]      bf_factor;
  logic             bf_vld;
  logic [31:0]      bf_yp;
  logic [31:0]      bf_yq;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_p;
  logic [LOG2N-1:0] wr_addr_q;
  logic [31:0]      wr_p;
  logic [31:0]      wr_q;

  modport master (
    output rd_en, rd_addr_p, rd_addr_q, tw_addr,
    output bf_en, bf_xp, bf_xq, bf_factor,
    output wr_en, wr_addr_p, wr_addr_q, wr_p, wr_q,
    input  rd_p, rd_q, tw, bf_vld, bf_yp, bf_yq
  );

  modport slave (
    input  rd_en, rd_addr_p, rd_addr_q, tw_addr,
    input  bf_en, bf_xp, bf_xq, bf_factor,
    input  wr_en, wr_addr_p, wr_addr_q, wr_p, wr_q,
    output rd_p, rd_q, tw, bf_vld, bf_yp, bf_yq
  );
endinterface

// File: rtl/fft_bf_sched.sv
// In-place radix-2 FFT butterfly scheduler: address generation, issue, write-back and stage hazards.
// Optional macro BF_SCHED_CHECK_EN enables the sticky bf_vld alignment check on err.
module fft_bf_sched #(
  parameter int LOG2N  = 8,
  parameter int BF_LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err,
  fft_bf_sched_if.master bus
);
  localparam int KW = LOG2N - 1;
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int DL = BF_LAT + 1;
`ifdef BF_SCHED_CHECK_EN
  localparam int VW = DL;
`else
  localparam int VW = DL - 1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [KW-1:0]    k_r;
  logic [SW-1:0]    stage_r;
  logic             bf_en_r;
  logic [LOG2N-1:0] dl_p_r [DL];
  logic [LOG2N-1:0] dl_q_r [DL];
  logic [VW-1:0]    dl_vld_r;

  logic             issue_s;
  logic             active_s;
  logic             last_k_s;
  logic             last_stage_s;
  logic             in_flight_s;
  logic [LOG2N-1:0] k_ext_s;
  logic [LOG2N-1:0] mask_s;
  logic [LOG2N-1:0] addr_p_s;
  logic [LOG2N-1:0] addr_q_s;
  logic [KW-1:0]    pos_s;
  logic [SW-1:0]    tw_sh_s;
  logic [KW-1:0]    tw_s;

  assign issue_s      = (state_r == ISSUE);
  assign active_s     = (state_r == ISSUE) || (state_r == DRAIN);
  assign last_k_s     = (k_r == {KW{1'b1}});
  assign last_stage_s = (stage_r == SW'(LOG2N - 1));
  // The tail entry is being written this cycle, so only earlier slots count as in flight.
  assign in_flight_s  = |dl_vld_r[DL-2:0];

  // Operand addresses: insert a zero at bit 'stage' of k to get p; q sets that bit.
  always_comb begin
    k_ext_s  = {1'b0, k_r};
    mask_s   = (LOG2N'(1) << stage_r) - LOG2N'(1);
    addr_p_s = ((k_ext_s & ~mask_s) << 1) | (k_ext_s & mask_s);
    addr_q_s = addr_p_s | (mask_s + LOG2N'(1));
    pos_s    = k_r & mask_s[KW-1:0];
    tw_sh_s  = SW'(LOG2N - 1) - stage_r;
    tw_s     = pos_s << tw_sh_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = ISSUE;
        else       state_s = IDLE;
      end
      ISSUE: begin
        if (last_k_s) state_s = DRAIN;
        else          state_s = ISSUE;
      end
      DRAIN: begin
        if (in_flight_s)       state_s = DRAIN;
        else if (last_stage_s) state_s = FIN;
        else                   state_s = ISSUE;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Butterfly index, stage counter and operand-valid strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r     <= {KW{1'b0}};
      stage_r <= {SW{1'b0}};
      bf_en_r <= 1'b0;
    end else begin
      bf_en_r <= issue_s;
      case (state_r)
        IDLE: begin
          k_r     <= {KW{1'b0}};
          stage_r <= {SW{1'b0}};
        end
        ISSUE: begin
          k_r <= k_r + KW'(1);
        end
        DRAIN: begin
          if (!in_flight_s && !last_stage_s) stage_r <= stage_r + SW'(1);
          else                               stage_r <= stage_r;
        end
        default: begin
          k_r     <= k_r;
          stage_r <= stage_r;
        end
      endcase
    end
  end

  // Write-address delay line with expected-valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DL; i++) begin
        dl_p_r[i] <= {LOG2N{1'b0}};
        dl_q_r[i] <= {LOG2N{1'b0}};
      end
      dl_vld_r <= {VW{1'b0}};
    end else begin
      dl_p_r[0]   <= bus.rd_addr_p;
      dl_q_r[0]   <= bus.rd_addr_q;
      dl_vld_r[0] <= issue_s;
      for (int i = 1; i < DL; i++) begin
        dl_p_r[i] <= dl_p_r[i-1];
        dl_q_r[i] <= dl_q_r[i-1];
      end
      for (int i = 1; i < VW; i++) begin
        dl_vld_r[i] <= dl_vld_r[i-1];
      end
    end
  end

`ifdef BF_SCHED_CHECK_EN
  logic err_r;

  // Sticky alignment error: butterfly result strobe disagrees with the expected slot
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (active_s && (bus.bf_vld != dl_vld_r[DL-1])) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign busy = active_s;
  assign done = (state_r == FIN);

  assign bus.rd_en     = issue_s;
  assign bus.rd_addr_p = issue_s ? addr_p_s : {LOG2N{1'b0}};
  assign bus.rd_addr_q = issue_s ? addr_q_s : {LOG2N{1'b0}};
  assign bus.tw_addr   = issue_s ? tw_s : {KW{1'b0}};

  assign bus.bf_en     = bf_en_r;
  assign bus.bf_xp     = bus.rd_p;
  assign bus.bf_xq     = bus.rd_q;
  assign bus.bf_factor = bus.tw;

  // Results arriving outside an active transform (e.g. after an abort) are dropped.
  assign bus.wr_en     = bus.bf_vld & active_s;
  assign bus.wr_addr_p = dl_p_r[DL-1];
  assign bus.wr_addr_q = dl_q_r[DL-1];
  assign bus.wr_p      = bus.bf_yp;
  assign bus.wr_q      = bus.bf_yq;
endmodule

// File: tb/tb_fft_bf_sched.sv
// Directed bench for fft_bf_sched: RAM/ROM models plus a 3-cycle pass-through butterfly.
module tb_fft_bf_sched;
  localparam int LOG2N  = 8;
  localparam int BF_LAT = 3;
  localparam int NB     = 128;
  localparam int STG    = 132;
`ifdef BF_SCHED_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic err;

  int cyc       = 0;
  int s0        = 0;
  int n_checks  = 0;
  int n_errors  = 0;
  int iss_cnt   = 0;
  int wr_cnt    = 0;
  int done_cnt  = 0;
  int drop_cyc  = -1;
  bit mon_en    = 1'b0;
  bit prev_en   = 1'b0;
  logic [31:0] prev_p, prev_q, prev_tw;

  logic [2:0]  bp_en = 3'b000;
  logic [31:0] bp_p [3];
  logic [31:0] bp_q [3];

  fft_bf_sched_if #(.LOG2N(LOG2N)) bus ();

  fft_bf_sched #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data RAM and twiddle ROM, one-cycle read latency; data tags its own address
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_p <= 32'h1000_0000 | 32'(bus.rd_addr_p);
      bus.rd_q <= 32'h1000_0000 | 32'(bus.rd_addr_q);
      bus.tw   <= 32'h7000_0000 | 32'(bus.tw_addr);
    end
  end

  // Butterfly: pass-through, BF_LAT cycles from bf_en to bf_vld; not reset on purpose
  always @(posedge clk) begin
    bp_en   <= {bp_en[1:0], bus.bf_en};
    bp_p[0] <= bus.bf_xp;
    bp_p[1] <= bp_p[0];
    bp_p[2] <= bp_p[1];
    bp_q[0] <= bus.bf_xq;
    bp_q[1] <= bp_q[0];
    bp_q[2] <= bp_q[1];
  end

  assign bus.bf_vld = bp_en[2] && (cyc != drop_cyc);
  assign bus.bf_yp  = bp_p[2];
  assign bus.bf_yq  = bp_q[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - s0);
    end
  endtask

  function automatic int m_p(input int s, input int k);
    int span;
    span = 1 << s;
    return (k >> s) * 2 * span + (k & (span - 1));
  endfunction

  function automatic int m_tw(input int s, input int k);
    return (k & ((1 << s) - 1)) << (LOG2N - 1 - s);
  endfunction

  // Per-cycle scoreboard: issue order/timing, operand pass-through, write-back, done
  task automatic monitor();
    int r, s, k, ep;
    r = cyc - s0;
    check_eq("bf_en", 32'(bus.bf_en), 32'(prev_en));
    if (prev_en) begin
      check_eq("bf_xp", bus.bf_xp, 32'h1000_0000 | prev_p);
      check_eq("bf_xq", bus.bf_xq, 32'h1000_0000 | prev_q);
      check_eq("bf_factor", bus.bf_factor, 32'h7000_0000 | prev_tw);
    end
    check_eq("busy", 32'(busy), 32'(r >= 1 && r <= 1056));
    if (bus.rd_en) begin
      s  = iss_cnt / NB;
      k  = iss_cnt % NB;
      ep = m_p(s, k);
      check_eq("rd_addr_p", 32'(bus.rd_addr_p), 32'(ep));
      check_eq("rd_addr_q", 32'(bus.rd_addr_q), 32'(ep + (1 << s)));
      check_eq("tw_addr", 32'(bus.tw_addr), 32'(m_tw(s, k)));
      check_eq("issue_cycle", 32'(r), 32'(1 + STG * s + k));
      iss_cnt++;
    end
    if (bus.wr_en) begin
      s  = wr_cnt / NB;
      k  = wr_cnt % NB;
      ep = m_p(s, k);
      check_eq("wr_addr_p", 32'(bus.wr_addr_p), 32'(ep));
      check_eq("wr_addr_q", 32'(bus.wr_addr_q), 32'(ep + (1 << s)));
      check_eq("wr_p", bus.wr_p, 32'h1000_0000 | 32'(ep));
      check_eq("wr_q", bus.wr_q, 32'h1000_0000 | 32'(ep + (1 << s)));
      check_eq("write_cycle", 32'(r), 32'(1 + STG * s + k + BF_LAT + 1));
      wr_cnt++;
    end
    if (done) begin
      check_eq("done_cycle", 32'(r), 32'd1057);
      done_cnt++;
    end
    prev_en = bus.rd_en;
    prev_p  = 32'(bus.rd_addr_p);
    prev_q  = 32'(bus.rd_addr_q);
    prev_tw = 32'(bus.tw_addr);
  endtask

  task automatic begin_run();
    s0       = cyc;
    iss_cnt  = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    prev_en  = 1'b0;
  endtask

  initial begin
    int nwr;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check_eq("rst_bf_en", 32'(bus.bf_en), 32'd0);
    check_eq("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_rd_addr_p", 32'(bus.rd_addr_p), 32'd0);
    check_eq("rst_rd_addr_q", 32'(bus.rd_addr_q), 32'd0);
    check_eq("rst_tw_addr", 32'(bus.tw_addr), 32'd0);
    check_eq("rst_wr_addr_p", 32'(bus.wr_addr_p), 32'd0);
    check_eq("rst_wr_addr_q", 32'(bus.wr_addr_q), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full transform; extra starts at cycle 300 and on the done cycle must be ignored
    begin_run();
    mon_en = 1'b1;
    for (int r = 0; r <= 1065; r++) begin
      if (r > 0) @(negedge clk);
      start = (r == 0) || (r == 300) || (r == 1057);
      if (r == 1) begin
        check_eq("c1_p", 32'(bus.rd_addr_p), 32'd0);
        check_eq("c1_q", 32'(bus.rd_addr_q), 32'd1);
        check_eq("c1_tw", 32'(bus.tw_addr), 32'd0);
      end
      if (r == 2) begin
        check_eq("c2_p", 32'(bus.rd_addr_p), 32'd2);
        check_eq("c2_q", 32'(bus.rd_addr_q), 32'd3);
      end
      if (r == 134) begin
        check_eq("s1k1_p", 32'(bus.rd_addr_p), 32'd1);
        check_eq("s1k1_q", 32'(bus.rd_addr_q), 32'd3);
        check_eq("s1k1_tw", 32'(bus.tw_addr), 32'd64);
      end
      if (r == 1057) begin
        check_eq("fin_done", 32'(done), 32'd1);
        check_eq("fin_busy", 32'(busy), 32'd0);
      end
      if (r == 1060) check_eq("late_start_ignored", 32'(bus.rd_en), 32'd0);
      monitor();
    end
    check_eq("run1_issues", 32'(iss_cnt), 32'd1024);
    check_eq("run1_writes", 32'(wr_cnt), 32'd1024);
    check_eq("run1_done_pulses", 32'(done_cnt), 32'd1);
    check_eq("run1_err", 32'(err), 32'd0);

    // Abort with reset at cycle 500, restart at cycle 510
    begin_run();
    for (int r = 0; r <= 510; r++) begin
      if (r > 0) @(negedge clk);
      start = (r == 0) || (r == 510);
      rst   = (r == 500);
      if (mon_en) monitor();
      if (r == 500) mon_en = 1'b0;
      if (r >= 501) begin
        check_eq("abort_wr_en", 32'(bus.wr_en), 32'd0);
        check_eq("abort_rd_en", 32'(bus.rd_en), 32'd0);
      end
    end
    begin_run();
    mon_en = 1'b1;
    for (int r = 1; r <= 1062; r++) begin
      @(negedge clk);
      start = 1'b0;
      if (r == 1) begin
        check_eq("restart_p", 32'(bus.rd_addr_p), 32'd0);
        check_eq("restart_q", 32'(bus.rd_addr_q), 32'd1);
      end
      monitor();
    end
    mon_en = 1'b0;
    check_eq("run2_writes", 32'(wr_cnt), 32'd1024);
    check_eq("run2_done_pulses", 32'(done_cnt), 32'd1);

    // Drop the stage-2, k=10 result strobe
    @(negedge clk);
    s0       = cyc;
    drop_cyc = s0 + 279;
    nwr      = 0;
    for (int r = 0; r <= 1062; r++) begin
      if (r > 0) @(negedge clk);
      start = (r == 0);
      if (bus.wr_en) nwr++;
      if (r == 279) check_eq("err_before_drop", 32'(err), 32'd0);
      if (r == 280) check_eq("err_after_drop", 32'(err), 32'(EXP_ERR));
      if (r == 1060) check_eq("err_sticky", 32'(err), 32'(EXP_ERR));
    end
    check_eq("drop_writes", 32'(nwr), 32'd1023);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("err_cleared", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
